// File: rtl/field_packer.sv
// field_packer: packs variable-length fields MSB-first into WORD_W-bit words.
// Define PACKER_PARITY_EN to add the even-parity output out_par_o.
module field_packer #(
    parameter int WORD_W  = 8,
    parameter int FIELD_W = 4,
    parameter int LEN_W   = $clog2(FIELD_W + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [FIELD_W-1:0] in_data_i,
    input  logic [LEN_W-1:0]   in_len_i,
    input  logic               in_flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
`ifdef PACKER_PARITY_EN
    output logic               out_par_o,
`endif
    output logic [WORD_W-1:0]  out_data_o
);
    localparam int AW = WORD_W + FIELD_W - 1;
    localparam int CW = $clog2(AW + 1);

    typedef enum logic {FILL, FLUSH} state_e;

    state_e        state_q;
    logic [AW-1:0] acc_q, acc_d, field;
    logic [CW-1:0] cnt_q, cnt_d, sh;
    logic          accept, emit;

    assign in_ready_o  = state_q == FILL && cnt_q < CW'(WORD_W);
    assign out_valid_o = cnt_q >= CW'(WORD_W) || (state_q == FLUSH && cnt_q != '0);
    assign out_data_o  = acc_q[AW-1 -: WORD_W];
`ifdef PACKER_PARITY_EN
    assign out_par_o   = ^out_data_o;
`endif
    assign accept = in_valid_i && in_ready_o;
    assign emit   = out_valid_o && out_ready_i;
    // masking drops bits above in_len; the shift lands the field just below the cnt valid bits
    assign field  = AW'(in_data_i & ~({FIELD_W{1'b1}} << in_len_i));
    assign sh     = CW'(AW) - cnt_q - CW'(in_len_i);

    always_comb begin
        acc_d = accept ? acc_q | (field << sh) : emit ? acc_q << WORD_W : acc_q;
        cnt_d = accept ? cnt_q + CW'(in_len_i)
              : emit ? (cnt_q >= CW'(WORD_W) ? cnt_q - CW'(WORD_W) : '0) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (accept && in_flush_i)
                state_q <= FLUSH;
            else if (state_q == FLUSH && cnt_q == '0)
                state_q <= FILL;
        end
    end
endmodule
